// File: rtl/icache_pkg.sv
// Shared types and parameter helpers for the 2-way burst-refill instruction cache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_pkg;

    // Controller states: serve lookups, or stream a missing line in from memory.
    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Tag width left over once the index, word offset and byte offset are removed.
    function automatic int t_width(input int a_width, input int c_index, input int c_offset);
        return a_width - c_index - c_offset - 2;
    endfunction

    // Words per cache line.
    function automatic int line_words(input int c_offset);
        return 1 << c_offset;
    endfunction

    // Burst counter width; kept at least one bit so single-word lines still elaborate.
    function automatic int cnt_width(input int c_offset);
        return (c_offset > 0) ? c_offset : 1;
    endfunction

    // LSB of the word-address field (bits below it select a byte).
    function automatic int word_lsb();
        return 2;
    endfunction

    // LSB of the set-index field.
    function automatic int idx_lsb(input int c_offset);
        return c_offset + 2;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit and tag, plus the line data store.
// Latency: reads are combinational; tag/data/valid writes land on the next rising edge.
// Backpressure: none; writes are accepted every cycle they are enabled.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset (clears valid bits only)
//   clr_i          clear every valid bit; wins over a simultaneous tag write
//   rd_idx_i       set index for the tag/valid lookup
//   rd_daddr_i     {index, word} address for the data read
//   wr_en_i        write wr_data_i into data word wr_daddr_i
//   tag_wr_i       write tag_i into set tag_idx_i and mark it valid
//   valid_o/tag_o/data_o  combinational read results
module icache_way
    import icache_pkg::*;
#(
    parameter int T_W   = 22,
    parameter int IDX_W = 6,
    parameter int DA_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [DA_W-1:0]  rd_daddr_i,
    input  logic             wr_en_i,
    input  logic [DA_W-1:0]  wr_daddr_i,
    input  logic [31:0]      wr_data_i,
    input  logic             tag_wr_i,
    input  logic [IDX_W-1:0] tag_idx_i,
    input  logic [T_W-1:0]   tag_i,
    output logic             valid_o,
    output logic [T_W-1:0]   tag_o,
    output logic [31:0]      data_o
);

    localparam int SETS  = 1 << IDX_W;
    localparam int DEPTH = 1 << DA_W;

    logic [SETS-1:0] valid_q;
    logic [T_W-1:0]  tag_q  [SETS];
    logic [31:0]     data_q [DEPTH];

    // Only the valid bits need a reset; stale tags/data are masked by valid=0.
    // Clear beats set so an invalidate landing on the last refill beat leaves the line invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (tag_wr_i) begin
            valid_q[tag_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr_i) begin
            tag_q[tag_idx_i] <= tag_i;
        end
        if (wr_en_i) begin
            data_q[wr_daddr_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign data_o  = data_q[rd_daddr_i];

endmodule

// File: rtl/i_cache_2way_burst.sv
// 2-way set-associative instruction cache with 1-bit LRU and word-by-word line refill.
// Latency: hits return combinationally in the request cycle; a miss costs LINE_WORDS m_ready beats + 1 cycle.
// Backpressure: p_ready stays low during refill, flush or invalidate; refill waits on m_ready per word.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   p_a/p_strobe         fetch byte address and request; address held until p_ready
//   p_flush              suppresses p_ready and miss start this cycle
//   p_inval              one-cycle pulse: invalidate every line in both ways
//   p_din/p_ready        instruction word and its valid strobe
//   cache_miss           combinational lookup miss for p_a while p_strobe
//   m_a/m_strobe         refill word address and read request (registered state)
//   m_dout/m_ready       refill data and its one-cycle acceptance pulse
module i_cache_2way_burst
    import icache_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic               p_strobe,
    input  logic               p_flush,
    input  logic               p_inval,
    output logic [31:0]        p_din,
    output logic               p_ready,
    output logic               cache_miss,
    output logic [A_WIDTH-1:0] m_a,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready
);

    localparam int T_W     = t_width(A_WIDTH, C_INDEX, C_OFFSET);
    localparam int LW      = line_words(C_OFFSET);
    localparam int CNT_W   = cnt_width(C_OFFSET);
    localparam int DA_W    = C_INDEX + C_OFFSET;
    localparam int SETS    = 1 << C_INDEX;
    localparam int IDX_LSB = idx_lsb(C_OFFSET);
    localparam int WRD_LSB = word_lsb();

    // ---------------------------------------------------------------
    // Address split. Index and word fields are adjacent, so the data
    // store is addressed by the contiguous {index, word} slice.
    // ---------------------------------------------------------------
    logic [T_W-1:0]     req_tag;
    logic [C_INDEX-1:0] req_idx;
    logic [DA_W-1:0]    req_daddr;
    logic               unused_byte_bits;

    assign req_tag          = p_a[A_WIDTH-1 -: T_W];
    assign req_idx          = p_a[IDX_LSB +: C_INDEX];
    assign req_daddr        = p_a[WRD_LSB +: DA_W];
    assign unused_byte_bits = ^p_a[1:0];

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [T_W-1:0]     line_tag_q,   line_tag_d;
    logic [C_INDEX-1:0] line_idx_q,   line_idx_d;
    logic               victim_q,     victim_d;
    logic               inval_pend_q, inval_pend_d;
    logic [SETS-1:0]    lru_q,        lru_d;
    logic               m_strobe_q,   m_strobe_d;

    // ---------------------------------------------------------------
    // Ways
    // ---------------------------------------------------------------
    logic             v0, v1;
    logic [T_W-1:0]   t0, t1;
    logic [31:0]      d0, d1;
    logic             way_wr;
    logic             tag_wr;
    logic             clr_all;
    logic [DA_W-1:0]  wr_daddr;

    assign wr_daddr = DA_W'((32'(line_idx_q) << C_OFFSET) | 32'(cnt_q));

    icache_way #(
        .T_W   (T_W),
        .IDX_W (C_INDEX),
        .DA_W  (DA_W)
    ) u_way0 (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_all),
        .rd_idx_i   (req_idx),
        .rd_daddr_i (req_daddr),
        .wr_en_i    (way_wr & ~victim_q),
        .wr_daddr_i (wr_daddr),
        .wr_data_i  (m_dout),
        .tag_wr_i   (tag_wr & ~victim_q),
        .tag_idx_i  (line_idx_q),
        .tag_i      (line_tag_q),
        .valid_o    (v0),
        .tag_o      (t0),
        .data_o     (d0)
    );

    icache_way #(
        .T_W   (T_W),
        .IDX_W (C_INDEX),
        .DA_W  (DA_W)
    ) u_way1 (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_all),
        .rd_idx_i   (req_idx),
        .rd_daddr_i (req_daddr),
        .wr_en_i    (way_wr & victim_q),
        .wr_daddr_i (wr_daddr),
        .wr_data_i  (m_dout),
        .tag_wr_i   (tag_wr & victim_q),
        .tag_idx_i  (line_idx_q),
        .tag_i      (line_tag_q),
        .valid_o    (v1),
        .tag_o      (t1),
        .data_o     (d1)
    );

    // ---------------------------------------------------------------
    // Lookup and fetch-side outputs
    // ---------------------------------------------------------------
    logic hit0, hit1, hit;
    logic hit_way;
    logic victim_sel;
    logic miss_start;
    logic cnt_last;

    assign hit0    = v0 & (t0 == req_tag);
    assign hit1    = v1 & (t1 == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;

    // Prefer an empty way so a cold set fills both ways before evicting.
    assign victim_sel = ~v0 ? 1'b0 : (~v1 ? 1'b1 : lru_q[req_idx]);

    assign p_ready    = (state_q == IDLE) & p_strobe & hit & ~p_flush & ~p_inval;
    assign p_din      = hit1 ? d1 : d0;
    assign cache_miss = p_strobe & ~hit;

    // An invalidate in the same cycle takes priority; the miss reissues next cycle.
    assign miss_start = (state_q == IDLE) & p_strobe & ~hit & ~p_flush & ~p_inval;
    assign cnt_last   = (32'(cnt_q) == LW - 1);

    assign m_strobe = m_strobe_q;
    assign m_a      = {line_tag_q, line_idx_q, {(C_OFFSET + 2){1'b0}}} | (A_WIDTH'(cnt_q) << 2);

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_tag_d   = line_tag_q;
        line_idx_d   = line_idx_q;
        victim_d     = victim_q;
        inval_pend_d = inval_pend_q;
        lru_d        = lru_q;
        m_strobe_d   = m_strobe_q;
        way_wr       = 1'b0;
        tag_wr       = 1'b0;
        clr_all      = 1'b0;

        case (state_q)
            IDLE: begin
                if (p_inval) begin
                    clr_all = 1'b1;
                end else if (miss_start) begin
                    line_tag_d = req_tag;
                    line_idx_d = req_idx;
                    victim_d   = victim_sel;
                    cnt_d      = '0;
                    m_strobe_d = 1'b1;
                    state_d    = REFILL;
                end else if (p_ready) begin
                    lru_d[req_idx] = ~hit_way;
                end
            end

            REFILL: begin
                // The refill always runs to completion; an invalidate is deferred
                // to the final beat so the new line ends up invalid too.
                if (p_inval) begin
                    inval_pend_d = 1'b1;
                end
                if (m_ready) begin
                    way_wr = 1'b1;
                    if (cnt_last) begin
                        tag_wr            = 1'b1;
                        clr_all           = inval_pend_q | p_inval;
                        inval_pend_d      = 1'b0;
                        lru_d[line_idx_q] = ~victim_q;
                        cnt_d             = '0;
                        m_strobe_d        = 1'b0;
                        state_d           = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                m_strobe_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Registers; reset aborts any refill in flight.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_tag_q   <= '0;
            line_idx_q   <= '0;
            victim_q     <= 1'b0;
            inval_pend_q <= 1'b0;
            lru_q        <= '0;
            m_strobe_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_tag_q   <= line_tag_d;
            line_idx_q   <= line_idx_d;
            victim_q     <= victim_d;
            inval_pend_q <= inval_pend_d;
            lru_q        <= lru_d;
            m_strobe_q   <= m_strobe_d;
        end
    end

    // A line is only ever filled after missing in both ways, so two ways can never hold it.
    a_single_way_hit: assert property (@(posedge clk) disable iff (rst) !(hit0 && hit1));

endmodule

// File: tb/tb_i_cache_2way_burst.sv
// Self-checking bench: directed cases on a C_OFFSET=2 instance, random LRU model runs on C_OFFSET=0/3.
// Latency: n/a.
// Backpressure: memory answers every other cycle while m_strobe is high.
module tb_i_cache_2way_burst;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] p_a        [ND];
    logic        p_strobe   [ND];
    logic        p_flush    [ND];
    logic        p_inval    [ND];
    logic [31:0] p_din      [ND];
    logic        p_ready    [ND];
    logic        cache_miss [ND];
    logic [31:0] m_a        [ND];
    logic        m_strobe   [ND];
    logic [31:0] m_dout     [ND];
    logic        m_ready    [ND];

    int          beats    [ND];
    int          obs_miss [ND];
    logic [31:0] mlog [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb [$];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        i_cache_2way_burst #(
            .A_WIDTH  (32),
            .C_INDEX  (6),
            .C_OFFSET (g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .p_a        (p_a[g]),
            .p_strobe   (p_strobe[g]),
            .p_flush    (p_flush[g]),
            .p_inval    (p_inval[g]),
            .p_din      (p_din[g]),
            .p_ready    (p_ready[g]),
            .cache_miss (cache_miss[g]),
            .m_a        (m_a[g]),
            .m_strobe   (m_strobe[g]),
            .m_dout     (m_dout[g]),
            .m_ready    (m_ready[g])
        );
    end

    function automatic int offs_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    endfunction

    // Backing memory content: odd multiplier keeps every word address distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory responder for all instances: one m_ready pulse every other cycle.
    initial begin
        for (int g = 0; g < ND; g++) begin
            m_ready[g] = 1'b0;
            m_dout[g]  = '0;
            beats[g]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < ND; g++) begin
                if (m_ready[g]) begin
                    m_ready[g] = 1'b0;
                end else if (m_strobe[g] && !rst) begin
                    m_ready[g] = 1'b1;
                    m_dout[g]  = mem_word(m_a[g]);
                    beats[g]++;
                    if (g == 0) mlog.push_back(m_a[g]);
                end
            end
        end
    end

    // One fetch: drive, check first-cycle miss flag, wait for p_ready, compare against scoreboard.
    task automatic fetch(input int g, input logic [31:0] addr, input bit exp_miss, input string tag);
        int   b0;
        int   waited;
        bit   got;
        exp_t e;
        @(negedge clk);
        p_a[g]      = addr;
        p_strobe[g] = 1'b1;
        sb.push_back('{addr, mem_word(addr)});
        b0 = beats[g];
        #1;
        check_eq({tag, "/miss"}, 32'(cache_miss[g]), 32'(exp_miss));
        if (cache_miss[g]) obs_miss[g]++;
        got    = 1'b0;
        waited = 0;
        for (int i = 0; i < 200; i++) begin
            if (p_ready[g]) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, "/ready"}, 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            check_eq({tag, "/data"}, p_din[g], e.data);
            check_eq({tag, "/beats"}, 32'(beats[g] - b0), exp_miss ? 32'(1 << offs_of(g)) : 32'd0);
            if (!exp_miss) check_eq({tag, "/lat"}, 32'(waited), 32'd0);
        end
        @(negedge clk);
        p_strobe[g] = 1'b0;
    endtask

    // Golden 2-way LRU model (one per random run).
    bit mv   [2][64];
    int mtag [2][64];
    bit mlru [64];

    task automatic random_run(input int g);
        int          offs;
        int          exp_misses;
        int          tagv, set, word, w;
        bit          miss;
        logic [31:0] addr;
        offs = offs_of(g);
        exp_misses = 0;
        obs_miss[g] = 0;
        for (int s = 0; s < 64; s++) begin
            mv[0][s] = 1'b0;
            mv[1][s] = 1'b0;
            mlru[s]  = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            tagv = int'($urandom_range(0, 3));
            set  = int'($urandom_range(0, 3));
            word = int'($urandom_range(0, (1 << offs) - 1));
            addr = (32'(tagv * 64 + set) << (offs + 2)) | (32'(word) << 2);
            if (mv[0][set] && mtag[0][set] == tagv) begin
                miss = 1'b0;
                w = 0;
            end else if (mv[1][set] && mtag[1][set] == tagv) begin
                miss = 1'b0;
                w = 1;
            end else begin
                miss = 1'b1;
                exp_misses++;
                w = !mv[0][set] ? 0 : (!mv[1][set] ? 1 : int'(mlru[set]));
                mv[w][set]   = 1'b1;
                mtag[w][set] = tagv;
            end
            mlru[set] = (w == 0);
            fetch(g, addr, miss, $sformatf("rnd%0d_%0d", g, i));
        end
        check_eq($sformatf("rnd%0d_miss_count", g), 32'(obs_miss[g]), 32'(exp_misses));
    endtask

    initial begin
        int b0;
        bit ok;
        for (int g = 0; g < ND; g++) begin
            p_a[g]      = '0;
            p_strobe[g] = 1'b0;
            p_flush[g]  = 1'b0;
            p_inval[g]  = 1'b0;
            obs_miss[g] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int g = 0; g < ND; g++) begin
            check_eq($sformatf("reset_mstrobe%0d", g), 32'(m_strobe[g]), 32'd0);
            check_eq($sformatf("reset_pready%0d", g), 32'(p_ready[g]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 1: cold miss and burst order, then same-line hit
        mlog.delete();
        fetch(0, 32'h0000_0040, 1'b1, "cold_40");
        check_eq("cold_burst_len", 32'(mlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (mlog.size() > 0) check_eq($sformatf("cold_m_a%0d", i), mlog.pop_front(), 32'h40 + 32'(4 * i));
        end
        fetch(0, 32'h0000_0048, 1'b0, "hit_48");

        // 2: LRU replacement in set 0
        fetch(0, 32'h0000_0000, 1'b1, "fill_000");
        fetch(0, 32'h0000_0400, 1'b1, "fill_400");
        fetch(0, 32'h0000_0000, 1'b0, "hit_000");
        fetch(0, 32'h0000_0800, 1'b1, "miss_800");
        fetch(0, 32'h0000_0000, 1'b0, "keep_000");
        fetch(0, 32'h0000_0400, 1'b1, "evict_400");

        // 3: flush gating
        @(negedge clk);
        p_a[0] = 32'h0000_0C00;
        p_strobe[0] = 1'b1;
        p_flush[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("flush_miss_ready%0d", i), 32'(p_ready[0]), 32'd0);
            check_eq($sformatf("flush_miss_mstrobe%0d", i), 32'(m_strobe[0]), 32'd0);
            @(negedge clk);
        end
        p_a[0] = 32'h0000_0000;
        #1;
        check_eq("flush_hit_miss", 32'(cache_miss[0]), 32'd0);
        check_eq("flush_hit_ready", 32'(p_ready[0]), 32'd0);
        p_flush[0] = 1'b0;
        #1;
        check_eq("unflush_hit_ready", 32'(p_ready[0]), 32'd1);
        @(negedge clk);
        p_strobe[0] = 1'b0;

        // 4: invalidate on the third refill beat
        @(negedge clk);
        p_a[0] = 32'h0000_1000;
        p_strobe[0] = 1'b1;
        b0 = beats[0];
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (m_ready[0] && beats[0] == b0 + 3) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("inval_beat3_seen", 32'(ok), 32'd1);
        p_inval[0] = 1'b1;
        @(negedge clk);
        p_inval[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!m_strobe[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("inval_refill_done", 32'(ok), 32'd1);
        check_eq("inval_refill_beats", 32'(beats[0] - b0), 32'd4);
        check_eq("inval_line_miss", 32'(cache_miss[0]), 32'd1);
        check_eq("inval_line_ready", 32'(p_ready[0]), 32'd0);
        p_strobe[0] = 1'b0;
        fetch(0, 32'h0000_1000, 1'b1, "inval_refilled");
        fetch(0, 32'h0000_0000, 1'b1, "inval_other");

        // 5: reset mid-refill
        @(negedge clk);
        p_a[0] = 32'h0000_2000;
        p_strobe[0] = 1'b1;
        b0 = beats[0];
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (beats[0] == b0 + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_two_beats", 32'(ok), 32'd1);
        @(negedge clk);
        #1;
        check_eq("rst_pre_mstrobe", 32'(m_strobe[0]), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_async_mstrobe", 32'(m_strobe[0]), 32'd0);
        @(negedge clk);
        p_strobe[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fetch(0, 32'h0000_2000, 1'b1, "rst_refetch");

        // 6: random streams against the LRU model
        random_run(1);
        random_run(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
